// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI Wishbone port arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_ACK,
    S_LOCK,
    S_RELEASE
  } state_t;

  // adr[2] selects between the spi_master data and control registers
  localparam logic SPI_REG_DATA = 1'b0;
  localparam logic SPI_REG_CTRL = 1'b1;

  localparam logic [3:0]  REL_SEL = 4'b1000;
  localparam logic [31:0] REL_DAT = 32'hFF00_0000;
  localparam logic [31:0] REL_ADR = {29'd0, SPI_REG_CTRL, 2'b00};

  // A write that reaches the chip-select byte of the control register
  function automatic logic is_cs_write(input logic [31:0] adr, input logic we,
                                       input logic [3:0] sel);
    return (adr[2] == SPI_REG_CTRL) && (adr[2] != SPI_REG_DATA) && we && sel[3];
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after last_i.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic            valid_o,
  output logic [IW-1:0]   idx_o
);

  logic [IW-1:0] j;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    j       = '0;
    for (int i = NREQ; i >= 1; i--) begin
      j = IW'((int'(last_i) + i) % NREQ);
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master Wishbone port among NREQ masters.
// Optional lock timeout release is enabled with `define SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int COUNT        = 4,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NREQ-1:0]            req_cyc_i,
  input  logic [NREQ-1:0]            req_stb_i,
  input  logic [NREQ-1:0]            req_we_i,
  input  logic [NREQ-1:0][31:0]      req_adr_i,
  input  logic [NREQ-1:0][3:0]       req_sel_i,
  input  logic [NREQ-1:0][31:0]      req_dat_i,
  output logic [NREQ-1:0][31:0]      req_dat_o,
  output logic [NREQ-1:0]            req_ack_o,
  output logic [NREQ-1:0]            req_stall_o,
  output logic                       spi_cyc_o,
  output logic                       spi_stb_o,
  output logic                       spi_we_o,
  output logic [31:0]                spi_adr_o,
  output logic [3:0]                 spi_sel_o,
  output logic [31:0]                spi_dat_o,
  input  logic [31:0]                spi_dat_i,
  input  logic                       spi_ack_i,
  output logic                       lock_expired_o
);

  localparam int IW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d, last_q, last_d;
  logic            lock_q, lock_d;
  logic [31:0]     adr_q, adr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic [3:0]      sel_q, sel_d;
  logic            we_q, we_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic [NREQ-1:0] cand, own_mask, pick_req;
  logic            pick_vld, accept;
  logic [IW-1:0]   pick_idx;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          exp_q, exp_d, rel_sent_q, rel_sent_d;
`endif

  assign cand     = req_cyc_i & req_stb_i;
  assign own_mask = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
  // While locked, only the owner is a candidate.
  assign pick_req = (state_q == S_LOCK) ? (cand & own_mask) : cand;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i   (pick_req),
    .last_i  (last_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  assign accept = rst_i && pick_vld && (state_q == S_IDLE || state_q == S_LOCK);

  always_comb begin
    req_stall_o = '1;
    if (accept) req_stall_o[pick_idx] = 1'b0;
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_dat
    assign req_dat_o[g] = rdat_q;
  end

  assign req_ack_o = ack_q & {NREQ{rst_i}};
`ifdef SPI_ARB_TIMEOUT_EN
  assign lock_expired_o = exp_q & rst_i;
`else
  assign lock_expired_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    lock_d  = lock_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdat_d  = rdat_q;
    ack_d   = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d      = '0;
    exp_d      = 1'b0;
    rel_sent_d = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_LOCK: begin
        if (accept) begin
          owner_d = pick_idx;
          adr_d   = req_adr_i[pick_idx];
          wdat_d  = req_dat_i[pick_idx];
          sel_d   = req_sel_i[pick_idx];
          we_d    = req_we_i[pick_idx];
          state_d = S_FWD;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (state_q == S_LOCK) begin
          if (cnt_q == CW'(LOCK_TIMEOUT - 1)) state_d = S_RELEASE;
          else                                cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      S_FWD: state_d = S_ACK;
      S_ACK: begin
        if (spi_ack_i) begin
          rdat_d         = spi_dat_i;
          ack_d[owner_q] = req_cyc_i[owner_q];
          if (is_cs_write(adr_q, we_q, sel_q))
            lock_d = (wdat_q[COUNT+23:24] != {COUNT{1'b1}});
          if (lock_d) begin
            state_d = S_LOCK;
          end else begin
            state_d = S_IDLE;
            last_d  = owner_q;
          end
        end
      end
`ifdef SPI_ARB_TIMEOUT_EN
      S_RELEASE: begin
        rel_sent_d = 1'b1;
        if (spi_ack_i) begin
          lock_d     = 1'b0;
          exp_d      = 1'b1;
          last_d     = owner_q;
          rel_sent_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Downstream drive is gated by reset so cyc drops in the first reset cycle.
  always_comb begin
    spi_cyc_o = 1'b0;
    spi_stb_o = 1'b0;
    spi_we_o  = 1'b0;
    spi_adr_o = '0;
    spi_sel_o = '0;
    spi_dat_o = '0;
    if (rst_i) begin
      case (state_q)
        S_FWD, S_ACK: begin
          spi_cyc_o = 1'b1;
          spi_stb_o = (state_q == S_FWD);
          spi_we_o  = we_q;
          spi_adr_o = adr_q;
          spi_sel_o = sel_q;
          spi_dat_o = wdat_q;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        S_RELEASE: begin
          spi_cyc_o = 1'b1;
          spi_stb_o = !rel_sent_q;
          spi_we_o  = 1'b1;
          spi_adr_o = REL_ADR;
          spi_sel_o = REL_SEL;
          spi_dat_o = REL_DAT;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      lock_q  <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdat_q  <= '0;
      ack_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      exp_q      <= 1'b0;
      rel_sent_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      rel_sent_q <= rel_sent_d;
`endif
    end
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares one `spi_master` Wishbone slave port between `NREQ` Wishbone masters (e.g. CPU and boot loader / DMA). Round-robin grant per bus cycle. Holds exclusive ownership while the owner has any chip select asserted, so multi-byte SPI transactions are never interleaved. Optional lock timeout forcibly deasserts selects if an owner abandons a transaction.

## Interface

- `NREQ`, 2: number of upstream requesters (≥2).
- `COUNT`, 4: chip-select width of the downstream `spi_master`; must match its `COUNT`.
- `LOCK_TIMEOUT`, 1000000: idle cycles in lock before forced release (only with `SPI_ARB_TIMEOUT_EN`).
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, synchronous, active-low.
- `req[NREQ]`  if_wb.slave  32-bit data  upstream ports; dat/adr/sel/we/cyc/stb/ack/stall.
- `spi`  if_wb.master  32-bit data  downstream port to `spi_master`.
- `lock_expired`  out  1  one-cycle pulse when a timeout release completes.

## Operation

- States: S_IDLE, S_FWD, S_ACK, S_LOCK, S_RELEASE.
- S_IDLE: candidates = requesters with `cyc & stb`. Round-robin pick starts at `(last_owner+1) mod NREQ`; after reset, requester 0 has priority. The winner is accepted this cycle: `owner <= k`, capture adr/dat/sel/we → S_FWD.
- `req[k].stall` = 0 only for the requester accepted this cycle; 1 otherwise, including during reset.
- S_FWD: downstream `cyc=1`, `stb=1` for exactly one cycle with captured fields → S_ACK.
- S_ACK: downstream `cyc=1`, `stb=0` until `spi.ack`. On ack, register `spi` dat into `req[owner].dat`, pulse `req[owner].ack` next cycle.
- Lock update on every forwarded write with `adr[2]=1`, `we=1`, `sel[3]=1`: `lock <= (dat[COUNT+23:24] != all-ones)`. Other accesses leave `lock` unchanged.
- After ack: `lock` set → S_LOCK; clear → S_IDLE, `last_owner <= owner`.
- S_LOCK: only `req[owner]` may be accepted (→ S_FWD). All other requesters stay stalled.
- Owner dropping `cyc` after acceptance: the downstream cycle completes; the upstream ack is suppressed if `req[owner].cyc` is low at ack time.
- Owner dropping `cyc` in S_LOCK does not release the lock.
- S_RELEASE (timeout only): downstream write `adr[2]=1`, `sel=4'b1000`, `dat=32'hFF00_0000`. One-cycle `stb`, hold `cyc` until ack, no upstream ack. Then `lock<=0`, pulse `lock_expired`, `last_owner <= owner` → S_IDLE.

## Timing

- Reset: state S_IDLE, `owner=0`, `last_owner=NREQ-1`, `lock=0`, timeout counter 0.
- Reset outputs: all downstream signals 0, all upstream `ack=0`, all `stall=1`, `lock_expired=0`.
- Reset mid-operation: the downstream `cyc` drops on the first reset cycle; pending acks are discarded.
- Latency: request accepted at T, downstream `stb` at T+1, `spi_master` ack at T+2, upstream ack at T+3. One transaction per 3 cycles minimum per requester.
- Back-to-back: a new accept is possible in the cycle the upstream ack is driven, from S_IDLE or S_LOCK.
- Downstream `stb` is never high for more than one cycle per transaction, so `spi_master` does not re-trigger from its S_DONE→S_IDLE return.
- Simultaneous requests in S_IDLE: exactly one is granted; the rest see `stall=1` and hold.

## Configuration

- `SPI_ARB_TIMEOUT_EN` defined:
  - Counter width `$clog2(LOCK_TIMEOUT+1)`, counts cycles in S_LOCK with no owner request.
  - Counter clears on every accept and on leaving S_LOCK.
  - Reaching `LOCK_TIMEOUT` → S_RELEASE.
- Not defined:
  - No counter and no S_RELEASE path.
  - `lock_expired` tied 0.
  - The lock persists until the owner writes all-ones selects or reset.

## Structure

- Package `spi_arb_pkg`:
  - `state_t` enum (S_IDLE, S_FWD, S_ACK, S_LOCK, S_RELEASE).
  - Register-select constants `SPI_REG_DATA=1'b0`, `SPI_REG_CTRL=1'b1`.
  - `REL_SEL=4'b1000`, `REL_DAT=32'hFF00_0000`.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs: request vector, `last_owner`. Outputs: valid, index (`$clog2(NREQ)` bits).

## Test plan

- Single read: req0 reads `adr=4` → stall low at T, `req[0].ack` at T+3 with status word from `spi_master`; req1 stalled throughout.
- Contention: req0 and req1 both write `adr=0` continuously, no locks → grants alternate 0,1,0,1; each ack 3 cycles after its accept.
- Lock: req1 writes `adr=4`, `sel=4'b1000`, `dat=32'h0E00_0000`, then two data writes; req0 requesting throughout stays stalled. req1 writes `dat=32'h0F00_0000` → req0 granted next.
- Abandon: req0 drops `cyc` the cycle after accept → downstream cycle completes, no `req[0].ack`, arbiter returns to S_IDLE.
- Timeout (`SPI_ARB_TIMEOUT_EN`, `LOCK_TIMEOUT=16`): req0 locks, then goes idle → after 16 cycles the downstream write is `dat=32'hFF00_0000`, `sel=4'b1000`; `lock_expired` pulses; req1 is served next.
- Reset during S_ACK: assert `rst_i=0` one cycle → downstream `cyc=0`, all stalls high, no ack emitted; normal arbitration resumes after release.
